// File: rtl/pcileech_com_txarb.sv
// pcileech_com_txarb
// Round-robin TX arbiter that merges several fixed-size frame producers onto
// the single 32-bit communication-core TX write channel. A grant covers whole
// frames only, lasts at most MAX_BURST frames, and is released early when the
// owner has nothing queued at a frame boundary. The write side is registered.

module pcileech_com_txarb #(
  parameter int NUM_SRC   = 3,
  parameter int FRAME_DW  = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_SRC-1:0]    src_valid,
  input  logic [NUM_SRC*32-1:0] src_data,
  output logic [NUM_SRC-1:0]    src_ready,
  output logic [31:0]           com_din,
  output logic                  com_din_wr_en,
  input  logic                  com_din_ready,
  output logic                  grant_valid,
  output logic [2:0]            grant_id,
  output logic [31:0]           frame_count
);

  localparam int WCW = $clog2(FRAME_DW);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  // Round-robin pick: first requester at or after (last+1) mod NUM_SRC.
  // Returns {found, index}. Walking the offsets from farthest to nearest lets
  // the nearest requester overwrite the result, so it wins.
  function automatic logic [3:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                         input logic [2:0]         last);
    logic [3:0] res;
    int         idx;
    res = 4'b0000;
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = int'(last) + k;
      if (idx >= NUM_SRC) begin
        idx = idx - NUM_SRC;
      end else begin
        idx = idx;
      end
      for (int j = 0; j < NUM_SRC; j++) begin
        if ((j == idx) && req[j]) begin
          res = {1'b1, 3'(j)};
        end else begin
          res = res;
        end
      end
    end
    return res;
  endfunction

  state_t             state_r, state_s;
  logic [2:0]         grant_r, grant_s;
  logic               grant_valid_r, grant_valid_s;
  logic [2:0]         last_grant_r, last_grant_s;
  logic [WCW-1:0]     word_cnt_r, word_cnt_s;
  logic [3:0]         burst_cnt_r, burst_cnt_s;
  logic [31:0]        frame_count_r, frame_count_s;
  logic [31:0]        com_din_r, com_din_s;
  logic               wr_en_r, wr_en_s;
  logic [NUM_SRC-1:0] src_ready_s;

  logic               g_valid_s;
  logic [31:0]        g_data_s;
  logic [3:0]         pick_s;
  logic               accept_s;
  logic               frame_end_s;
  logic               burst_more_s;
  logic               boundary_s;

  assign pick_s = rr_pick(src_valid, last_grant_r);

  // Route the owning producer's valid and data through an AND-OR mux
  always_comb begin
    g_valid_s = 1'b0;
    g_data_s  = 32'h0000_0000;
    for (int i = 0; i < NUM_SRC; i++) begin
      g_valid_s = g_valid_s | (src_valid[i] & (grant_r == 3'(i)));
      g_data_s  = g_data_s  | (src_data[i*32 +: 32] & {32{grant_r == 3'(i)}});
    end
  end

  // A word moves only while the channel is owned and the TX FIFO has room
  assign accept_s     = (state_r == ST_XFER) & g_valid_s & com_din_ready;
  assign frame_end_s  = accept_s & (word_cnt_r == WCW'(FRAME_DW - 1));
  assign burst_more_s = ({1'b0, burst_cnt_r} + 5'd1) < 5'(MAX_BURST);
  // Between two frames of the same grant: no word of the next frame taken yet
  assign boundary_s   = (word_cnt_r == '0) && (burst_cnt_r != 4'd0);

  // Next-state, counters, grant bookkeeping and the ready fan-out
  always_comb begin
    state_s       = state_r;
    grant_s       = grant_r;
    grant_valid_s = grant_valid_r;
    last_grant_s  = last_grant_r;
    word_cnt_s    = word_cnt_r;
    burst_cnt_s   = burst_cnt_r;
    frame_count_s = frame_count_r;
    com_din_s     = com_din_r;
    wr_en_s       = 1'b0;
    src_ready_s   = '0;

    case (state_r)
      ST_IDLE: begin
        if (pick_s[3]) begin
          grant_s       = pick_s[2:0];
          grant_valid_s = 1'b1;
          word_cnt_s    = '0;
          burst_cnt_s   = 4'd0;
          state_s       = ST_XFER;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_XFER: begin
        for (int i = 0; i < NUM_SRC; i++) begin
          src_ready_s[i] = com_din_ready & (grant_r == 3'(i));
        end
        if (accept_s) begin
          com_din_s = g_data_s;
          wr_en_s   = 1'b1;
          if (frame_end_s) begin
            frame_count_s = frame_count_r + 32'd1;
            burst_cnt_s   = burst_cnt_r + 4'd1;
            word_cnt_s    = '0;
            if (burst_more_s) begin
              state_s = ST_XFER;
            end else begin
              // Burst budget spent: owner drops to lowest priority
              last_grant_s  = grant_r;
              grant_valid_s = 1'b0;
              state_s       = ST_IDLE;
            end
          end else begin
            word_cnt_s = word_cnt_r + WCW'(1);
          end
        end else if (boundary_s && !g_valid_s) begin
          // Owner has nothing queued at a frame boundary: hand the channel back
          last_grant_s  = grant_r;
          grant_valid_s = 1'b0;
          state_s       = ST_IDLE;
        end else begin
          // Mid-frame stall (producer or FIFO): keep the grant, never interleave
          state_s = ST_XFER;
        end
      end

      default: begin
        grant_valid_s = 1'b0;
        state_s       = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any partial frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      grant_r       <= 3'd0;
      grant_valid_r <= 1'b0;
      last_grant_r  <= 3'(NUM_SRC - 1);
      word_cnt_r    <= '0;
      burst_cnt_r   <= 4'd0;
      frame_count_r <= 32'd0;
      com_din_r     <= 32'd0;
      wr_en_r       <= 1'b0;
    end else begin
      state_r       <= state_s;
      grant_r       <= grant_s;
      grant_valid_r <= grant_valid_s;
      last_grant_r  <= last_grant_s;
      word_cnt_r    <= word_cnt_s;
      burst_cnt_r   <= burst_cnt_s;
      frame_count_r <= frame_count_s;
      com_din_r     <= com_din_s;
      wr_en_r       <= wr_en_s;
    end
  end

  assign src_ready     = src_ready_s;
  assign com_din       = com_din_r;
  assign com_din_wr_en = wr_en_r;
  assign grant_valid   = grant_valid_r;
  assign grant_id      = grant_r;
  assign frame_count   = frame_count_r;

endmodule

// File: doc/pcileech_com_txarb.md
# pcileech_com_txarb

Round-robin TX arbiter between several frame producers and the single 32-bit communication-core TX input (the `dfifo.com_din` / `com_din_wr_en` / `com_din_ready` channel). Producers are the TLP return path, the command/status responder and the loopback/test generator. Each producer emits fixed-size frames of FRAME_DW DWORDs; this keeps FT601 and Ethernet transfers 32-byte aligned. The arbiter grants one producer at a time, forwards whole frames without interleaving, honours TX back-pressure and bounds each grant to a burst limit.

## Interface
Parameters:
- NUM_SRC, 3: number of producers (2..8).
- FRAME_DW, 8: DWORDs per frame (power of two, 2..64).
- MAX_BURST, 4: maximum consecutive frames per grant before rotation (1..15).

Ports:
- clk  in  1  system clock, 100 MHz (single clock domain).
- rst_n  in  1  asynchronous, active-low reset.
- src_valid  in  NUM_SRC  producer i has a DWORD on src_data[i].
- src_data  in  NUM_SRC*32  producer DWORDs; producer i occupies bits [32i+31:32i].
- src_ready  out  NUM_SRC  DWORD accepted from producer i this cycle, when src_valid[i] is also high.
- com_din  out  32  DWORD to the communication-core TX FIFO.
- com_din_wr_en  out  1  com_din write strobe.
- com_din_ready  in  1  TX FIFO can accept a write (inverse of almost_full).
- grant_valid  out  1  a producer currently owns the channel.
- grant_id  out  3  index of the owning producer.
- frame_count  out  32  total frames completed since reset; wraps.

## Operation
- State machine: IDLE, XFER.
- IDLE:
  - Request vector is src_valid.
  - If any bit is set, select the first requester at or after (last_grant+1) mod NUM_SRC.
  - Load grant_id with the selection, set grant_valid=1, clear word_cnt and burst_cnt, go to XFER.
  - If no bit is set, remain in IDLE.
- XFER:
  - src_ready[grant_id] = com_din_ready (combinational); all other src_ready are 0.
  - A word is accepted when src_valid[g] & src_ready[g]; only then does word_cnt increment.
  - The producer may drop src_valid mid-frame. The grant is held, with no timeout and no interleaving, until FRAME_DW words have been accepted.
- Frame end: the accepted word with word_cnt = FRAME_DW-1.
  - frame_count += 1, burst_cnt += 1, word_cnt returns to 0.
  - Stay in XFER if burst_cnt+1 < MAX_BURST.
  - Otherwise: last_grant <= grant_id, grant_valid <= 0, go to IDLE.
- Source going idle at a frame boundary: if the producer has src_valid low on the cycle after a frame end, the grant is released immediately (last_grant updated, back to IDLE). No wait for a next frame.
- Data path is registered:
  - com_din <= src_data[g] and com_din_wr_en <= 1 on each accepted word.
  - Otherwise com_din_wr_en <= 0 and com_din holds its value.
- Width rules:
  - word_cnt is $clog2(FRAME_DW) bits and wraps naturally.
  - burst_cnt is 4 bits.
  - grant_id is zero-extended to 3 bits.
- Reset (asynchronous, any time, including mid-frame):
  - state=IDLE, last_grant=NUM_SRC-1 (so producer 0 wins first), word_cnt=0, burst_cnt=0.
  - Outputs: com_din=0, com_din_wr_en=0, src_ready=0, grant_valid=0, grant_id=0, frame_count=0.
  - A partially transferred frame is abandoned; producers restart their frames after reset.

## Timing
- Arbitration: 1 cycle. Requests sampled in IDLE give grant_valid=1 on the next edge, and src_ready may assert in that same XFER cycle.
- Datapath latency: 1 cycle from acceptance (src_valid&src_ready) to com_din_wr_en.
- Within a grant, frames are back-to-back with zero bubbles while com_din_ready=1 and src_valid=1.
- Rotation between producers costs exactly 1 idle cycle (the IDLE state).
- Back-pressure:
  - com_din_ready low blocks acceptance in the same cycle.
  - One already-registered write may still be issued the cycle after ready falls; the TX FIFO almost_full margin absorbs it.
- Simultaneous events:
  - Frame end while other producers request: the rotation pointer decides; the current producer is lowest priority next time.
  - Frame end on the same cycle com_din_ready falls: the word is still counted, because it was accepted before the fall.
- Throughput: with a single requester, MAX_BURST frames per (MAX_BURST*FRAME_DW + 1) cycles.

## Test plan
- Reset, then producer 1 alone sends 1 frame of DWORDs 0x10..0x17. Required: com_din sequence 0x10..0x17 on 8 consecutive wr_en cycles, first wr_en 2 cycles after src_valid rises, frame_count=1, grant_valid=0 afterwards.
- All 3 producers continuously valid, MAX_BURST=4. Required: grant order 0,1,2,0; each grant is 4 frames (32 words) with no gaps; exactly 1 idle cycle between grants.
- Producer 0 mid-frame, com_din_ready toggles 1,0,0,1 every 4 cycles. Required: no wr_en while ready=0 (beyond the 1 registered word), all 8 words delivered in order, no word duplicated or lost.
- Producer 2 drops src_valid for 5 cycles after word 3 while producer 0 requests. Required: grant stays 2, producer 0 stays unserved, and producer 2's frame completes before grant_id changes.
- rst_n asserted low mid-frame after word 4. Required: all outputs 0 immediately (asynchronously). After release, producer 0 is granted first and frame_count restarts at 0.
- Force frame_count to 0xFFFFFFFF (hierarchical deposit) then complete a frame. Required: frame_count=0x00000000.
